// File: rtl/prog_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_mem_loader_pkg
//   Shared definitions for the program/data memory boot loader:
//   loader FSM state encoding, processor rw polarity and default
//   address/data widths matching the 8-bit accumulator processor.
// ---------------------------------------------------------------------------
package prog_mem_loader_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 16;

    // Loader FSM: header byte, high data byte, low data byte, processor run
    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_HI  = 2'd1,
        ST_LO  = 2'd2,
        ST_RUN = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/prog_mem_loader_ram_sp_async.sv
// ---------------------------------------------------------------------------
// ram_sp_async
//   DEPTH x DW memory, one synchronous write port, one asynchronous read port.
//   Contents are never reset.
// Ports:
//   i_clk    write clock (rising edge)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module ram_sp_async #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
//   Program/data memory plus byte-serial boot loader for the 8-bit
//   accumulator processor. After reset it receives a header byte N
//   (0 means DEPTH) followed by N {hi, lo} byte pairs, writing words from
//   address 0 upward while holding the processor in clear. It then
//   releases the processor and serves its reads/writes until ld_reload.
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-low reset
//   ld_valid    load byte valid
//   ld_data     load byte
//   ld_ready    loader can accept a byte (low in RUN)
//   ld_reload   request new program load (sampled in RUN only)
//   cpu_adrs    processor address
//   cpu_rw      processor rw: 1 = read, 0 = write
//   cpu_dout    processor write data
//   cpu_din     word returned to processor (zero outside RUN)
//   cpu_clr     registered active-low clear to processor
//   load_done   high while in RUN
//   load_count  words written by current/last load
// ---------------------------------------------------------------------------
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          ld_reload,
    input  logic [AW-1:0] cpu_adrs,
    input  logic          cpu_rw,
    input  logic [7:0]    cpu_dout,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_clr,
    output logic          load_done,
    output logic [AW:0]   load_count
);

    state_t        r_state;
    logic [AW:0]   r_n;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_hi;
    logic          r_cpu_clr;
    logic          r_load_done;

    logic          w_run;
    logic          w_xfer;
    logic [AW:0]   w_count_nxt;
    logic [AW:0]   w_hdr_n;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;

    assign w_run       = (r_state == ST_RUN);
    assign ld_ready    = !w_run;
    assign w_xfer      = ld_valid && ld_ready;
    assign w_count_nxt = r_count + 1'b1;
    // Header value 0 encodes a full-memory load
    assign w_hdr_n     = (ld_data == 8'd0) ? (AW+1)'(DEPTH) : (AW+1)'(ld_data);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_HDR;
            r_n         <= '0;
            r_count     <= '0;
            r_addr      <= '0;
            r_hi        <= '0;
            r_cpu_clr   <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        r_n     <= w_hdr_n;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_xfer) begin
                        r_hi    <= ld_data;
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_xfer) begin
                        r_addr  <= r_addr + 1'b1;
                        r_count <= w_count_nxt;
                        // cpu_clr/load_done are set together with the RUN
                        // transition so they rise on the same edge
                        if (w_count_nxt == r_n) begin
                            r_state     <= ST_RUN;
                            r_cpu_clr   <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_HI;
                        end
                    end
                end
                ST_RUN: begin
                    if (ld_reload) begin
                        r_state     <= ST_HDR;
                        r_cpu_clr   <= 1'b0;
                        r_load_done <= 1'b0;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    // Single write port: loader owns it outside RUN, processor inside RUN
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr;
        w_wdata = DW'({r_hi, ld_data});
        if (w_run) begin
            w_we    = (cpu_rw == RW_WRITE);
            w_waddr = cpu_adrs;
            w_wdata = DW'(cpu_dout);
        end else if (r_state == ST_LO) begin
            w_we = w_xfer;
        end
    end

    ram_sp_async #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (cpu_adrs),
        .o_rdata (w_rdata)
    );

    assign cpu_din    = w_run ? w_rdata : '0;
    assign cpu_clr    = r_cpu_clr;
    assign load_done  = r_load_done;
    assign load_count = r_count;

endmodule
